mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data bus, sitting beside data_mem downstream of the riscv core.
- The core stores bytes into a small TX FIFO. A baud-rate FSM serialises them as 8N1 frames on `tx`.
- Gives test programs a console/trace path; `sel` lets the SoC mux this block's `data_o` against data_mem's read data.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register word offsets (addr[3:2]), STATUS bit positions,
// frame geometry and the serialiser FSM state encoding.
package uart_pkg;

  // Register word offsets, decoded from addr[3:2]
  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  // STATUS bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_ACTIVE    = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  // 8N1 frame: start + 8 data + stop
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // A divisor of zero would stall the bit timer, so it is treated as one
  function automatic logic [15:0] effective_div(input logic [15:0] baud_div);
    return (baud_div == 16'd0) ? 16'd1 : baud_div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding bytes waiting for the serialiser.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   push, wdata   write request and data; dropped when full unless a pop
//                 happens in the same cycle
//   pop           read request; ignored when empty
//   rdata         head entry (valid while !empty)
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop is resolved first, so a push into a full FIFO still lands when
  // the same edge frees a slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter sitting beside data_mem on the core bus.
// Bytes written to TXDATA queue in a FIFO and are sent as 8N1 frames.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   ce, we     bus chip enable and write enable
//   addr       byte address; hit when addr[31:4] == BASE_ADDR[31:4]
//   data_i     write data
//   data_o     combinational read data (0 when not reading this block)
//   sel        combinational ce && hit, for the SoC read-data mux
//   tx         serial line, idle high
//   tx_busy    frame on the line or bytes still queued
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    reg_sel;
  logic          push_req;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   div_m1;

  uart_state_t   state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [15:0]   baud_cnt;
  logic          tx_q;
  logic          bit_end;

  logic [31:0]   status_word;
  logic          unused_bits;

  // Byte lanes and upper write data are not used by any register
  assign unused_bits = ^{addr[1:0], data_i[31:16]};

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = ce && hit;
  assign wr_en    = sel && we;
  assign rd_en    = sel && !we;
  assign reg_sel  = addr[3:2];
  assign push_req = wr_en && (reg_sel == REG_TXDATA);

  // The FSM takes the head byte on its first idle cycle
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (data_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Reload value is sampled at each bit boundary, so a divisor change
  // mid-frame only affects the following bit
  assign div_m1  = effective_div(baud_div) - 16'd1;
  assign bit_end = (baud_cnt == 16'd0);

  // Divisor register and sticky overflow flag; an overflow only happens
  // when a push meets a full FIFO that is not being drained that edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == REG_BAUD_DIV)) baud_div <= data_i[15:0];
      if (wr_en && (reg_sel == REG_STATUS) && data_i[STAT_OVERFLOW]) begin
        overflow <= 1'b0;
      end else if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Serialiser: tx is registered together with the state so the line
  // changes only on clock edges; each bit lasts div cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= fifo_rdata;
            baud_cnt <= div_m1;
            tx_q     <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= div_m1;
            bit_idx  <= '0;
            tx_q     <= shreg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= div_m1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx_q  <= 1'b1;
              state <= ST_STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state != ST_IDLE) || !fifo_empty;

  // Read mux; anything other than a read hit returns zero
  always_comb begin
    status_word                          = '0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_ACTIVE]             = (state != ST_IDLE);
    status_word[STAT_OVERFLOW]           = overflow;
    status_word[STAT_COUNT_LSB +: CW]    = fifo_count;

    data_o = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_STATUS:   data_o = status_word;
        REG_BAUD_DIV: data_o = {16'h0000, baud_div};
        default:      data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx.
// The reference model schedules every accepted byte as a frame with a pop
// edge and divisor, and derives tx, tx_busy and STATUS from that schedule.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  longint edge_no = 0;

  typedef struct {
    longint     push_e;
    longint     pop_e;
    logic [7:0] b;
    int         d;
  } frame_t;

  frame_t      frames[$];
  logic [15:0] model_baud;
  bit          model_ovf;

  mmio_uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .data_i  (data_i),
    .data_o  (data_o),
    .sel     (sel),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter; read only at falling edges where it is stable
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic int eff_div();
    return (model_baud == 16'd0) ? 1 : int'(model_baud);
  endfunction

  // Queue a byte pushed at edge e; returns 0 if the FIFO would be full
  function automatic bit model_push(longint e, logic [7:0] b);
    int     occ = 0;
    longint p;
    frame_t f;
    foreach (frames[i]) begin
      if (frames[i].push_e < e && frames[i].pop_e > e) occ++;
    end
    if (occ >= DEPTH) begin
      model_ovf = 1'b1;
      return 1'b0;
    end
    p = e + 1;
    if (frames.size() > 0) begin
      f = frames[frames.size() - 1];
      if (f.pop_e + 10 * f.d + 1 > p) p = f.pop_e + 10 * f.d + 1;
    end
    f.push_e = e;
    f.pop_e  = p;
    f.b      = b;
    f.d      = eff_div();
    frames.push_back(f);
    return 1'b1;
  endfunction

  // Line level shown after edge e
  function automatic logic model_tx(longint e);
    longint j;
    foreach (frames[i]) begin
      if (e >= frames[i].pop_e && e < frames[i].pop_e + 10 * frames[i].d) begin
        j = (e - frames[i].pop_e) / frames[i].d;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return frames[i].b[int'(j - 1)];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(longint e);
    foreach (frames[i]) begin
      if (frames[i].push_e <= e && e < frames[i].pop_e + 10 * frames[i].d) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_status(longint e);
    int          cnt = 0;
    bit          act = 1'b0;
    logic [31:0] s   = '0;
    foreach (frames[i]) begin
      if (frames[i].push_e <= e && frames[i].pop_e > e) cnt++;
      if (frames[i].pop_e <= e && e < frames[i].pop_e + 10 * frames[i].d) act = 1'b1;
    end
    s[0]    = (cnt == DEPTH);
    s[1]    = (cnt == 0);
    s[2]    = act;
    s[3]    = model_ovf;
    s[12:8] = 5'(cnt);
    return s;
  endfunction

  function automatic longint model_last_end();
    longint m = 0;
    foreach (frames[i]) begin
      if (frames[i].pop_e + 10 * frames[i].d > m) m = frames[i].pop_e + 10 * frames[i].d;
    end
    return m;
  endfunction

  function automatic longint model_next_pop(longint e);
    foreach (frames[i]) begin
      if (frames[i].pop_e > e) return frames[i].pop_e;
    end
    return e + 1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++;
    if (data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_o: got %h expected 0", data_o); end
    ce = 1'b1; addr = BASE + 32'h4; #1;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 1", sel); end
    checks++;
    if (data_o !== 32'h0000_0002) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000002", data_o); end
    addr = BASE + 32'h8; #1;
    checks++;
    if (data_o !== 32'd868) begin errors++; $display("[TB] FAIL reset_baud: got %0d expected 868", data_o); end
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    frames.delete();
    model_baud = 16'd868;
    model_ovf  = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    bit         acc;
    longint     end_e;
    frames.delete();
    for (int k = 0; k < 2; k++) begin
      model_baud = (k == 0) ? 16'd4 : 16'($urandom_range(1, 5));
      b          = (k == 0) ? 8'hA5 : 8'($urandom);
      bus_write(BASE + 32'h8, {16'h0, model_baud});
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = BASE; data_i = {24'h0, b};
      acc = model_push(edge_no + 1, b);
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
      end_e = model_last_end();
      for (int i = 0; i < 3000 && edge_no <= end_e + 2; i++) begin
        @(negedge clk);
        checks++;
        if (tx !== model_tx(edge_no))
          begin errors++; $display("[TB] FAIL frame_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
        checks++;
        if (tx_busy !== model_busy(edge_no))
          begin errors++; $display("[TB] FAIL frame_busy edge %0d: got %b expected %b", edge_no, tx_busy, model_busy(edge_no)); end
      end
    end
    ce = 1'b1; we = 1'b0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL frame_status_idle: got %h expected %h", data_o, model_status(edge_no)); end
    ce = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    bit         acc;
    longint     p;
    longint     end_e;
    frames.delete();
    model_baud = 16'd2;
    bus_write(BASE + 32'h8, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== model_tx(edge_no))
        begin errors++; $display("[TB] FAIL burst_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
      data_i = $urandom;
      b = data_i[7:0];
      ce = 1'b1; we = 1'b1; addr = BASE;
      acc = model_push(edge_no + 1, b);
    end
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL overflow_status: got %h expected %h", data_o, model_status(edge_no)); end
    @(negedge clk);
    we = 1'b1; data_i = 32'h8;
    model_ovf = 1'b0;
    @(negedge clk);
    we = 1'b0; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL overflow_clear: got %h expected %h", data_o, model_status(edge_no)); end
    ce = 1'b0;
    p = model_next_pop(edge_no);
    for (int i = 0; i < 500 && edge_no < p - 1; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== model_tx(edge_no))
        begin errors++; $display("[TB] FAIL full_wait_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
    end
    if (edge_no != p - 1) begin errors++; $display("[TB] FAIL full_wait_bound: edge %0d expected %0d", edge_no, p - 1); end
    data_i = $urandom;
    ce = 1'b1; we = 1'b1; addr = BASE;
    acc = model_push(p, data_i[7:0]);
    @(negedge clk);
    we = 1'b0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL full_pop_push_status: got %h expected %h", data_o, model_status(edge_no)); end
    ce = 1'b0;
    end_e = model_last_end();
    for (int i = 0; i < 5000 && edge_no <= end_e + 2; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== model_tx(edge_no))
        begin errors++; $display("[TB] FAIL drain_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
      checks++;
      if (tx_busy !== model_busy(edge_no))
        begin errors++; $display("[TB] FAIL drain_busy edge %0d: got %b expected %b", edge_no, tx_busy, model_busy(edge_no)); end
    end
  endtask

  task automatic test_div_zero_reset();
    bit     acc;
    longint target;
    frames.delete();
    model_baud = 16'd0;
    bus_write(BASE + 32'h8, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data_i = $urandom;
      ce = 1'b1; we = 1'b1; addr = BASE;
      acc = model_push(edge_no + 1, data_i[7:0]);
    end
    target = frames[0].pop_e + 3;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
    for (int i = 0; i < 100 && edge_no < target; i++) begin
      checks++;
      if (tx !== model_tx(edge_no))
        begin errors++; $display("[TB] FAIL div0_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
      @(negedge clk);
    end
    rst = 1'b0; #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL midframe_reset_tx: got %b expected 1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL midframe_reset_busy: got %b expected 0", tx_busy); end
    frames.delete();
    model_ovf  = 1'b0;
    model_baud = 16'd868;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== model_tx(edge_no))
        begin errors++; $display("[TB] FAIL post_reset_tx edge %0d: got %b expected %b", edge_no, tx, model_tx(edge_no)); end
      checks++;
      if (tx_busy !== model_busy(edge_no))
        begin errors++; $display("[TB] FAIL post_reset_busy edge %0d: got %b expected %b", edge_no, tx_busy, model_busy(edge_no)); end
    end
    ce = 1'b1; we = 1'b0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL post_reset_status: got %h expected %h", data_o, model_status(edge_no)); end
    addr = BASE + 32'h8; #1;
    checks++;
    if (data_o !== {16'h0, model_baud})
      begin errors++; $display("[TB] FAIL post_reset_baud: got %h expected %h", data_o, {16'h0, model_baud}); end
    ce = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] a;
    logic [31:0] exp_data;
    bit          hit;
    bit          exp_sel;
    frames.delete();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      hit = 1'($urandom_range(0, 1));
      a   = $urandom;
      if (hit) a = {BASE[31:4], a[3:0]};
      else if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
      ce = 1'($urandom_range(0, 1)); we = 1'b0; addr = a; #1;
      exp_sel  = ce && hit;
      exp_data = '0;
      if (exp_sel) begin
        case (a[3:2])
          2'd1:    exp_data = model_status(edge_no);
          2'd2:    exp_data = {16'h0, model_baud};
          default: exp_data = '0;
        endcase
      end
      checks++;
      if (sel !== exp_sel)
        begin errors++; $display("[TB] FAIL decode_sel addr %h ce %b: got %b expected %b", a, ce, sel, exp_sel); end
      checks++;
      if (data_o !== exp_data)
        begin errors++; $display("[TB] FAIL decode_read addr %h ce %b: got %h expected %h", a, ce, data_o, exp_data); end
    end
    bus_write(BASE + 32'hC, $urandom);
    bus_write(32'h2000_0000, 32'h55);
    bus_write(BASE + 32'h8, 32'hABCD_0007);
    model_baud = 16'd7;
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== model_status(edge_no))
      begin errors++; $display("[TB] FAIL ignored_writes_status: got %h expected %h", data_o, model_status(edge_no)); end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL ignored_writes_tx: got %b expected 1", tx); end
    addr = BASE + 32'h8; #1;
    checks++;
    if (data_o !== 32'h0000_0007) begin errors++; $display("[TB] FAIL baud_rw: got %h expected 00000007", data_o); end
    we = 1'b1; data_i = 32'h0; addr = BASE + 32'h4; #1;
    checks++;
    if (data_o !== 32'h0) begin errors++; $display("[TB] FAIL write_cycle_read: got %h expected 0", data_o); end
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_baud = 16'd868;
    model_ovf  = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_div_zero_reset();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
